// File: rtl/wbarbiter_n.sv
// wbarbiter_n: NM-master to one-slave pipelined Wishbone arbiter.
// Fixed-priority or round-robin grant taken from IDLE, owner index output,
// and a watchdog that aborts a cycle the slave never acknowledges.
module wbarbiter_n #(
    parameter int NM      = 4,
    parameter int AW      = 19,
    parameter int DW      = 32,
    parameter int OPT_RR  = 1,
    parameter int TIMEOUT = 1024,
    localparam int LGNM   = $clog2(NM)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NM-1:0]       i_cyc,
    input  logic [NM-1:0]       i_stb,
    input  logic [NM-1:0]       i_we,
    input  logic [NM*AW-1:0]    i_adr,
    input  logic [NM*DW-1:0]    i_dat,
    output logic [NM-1:0]       o_ack,
    output logic [NM-1:0]       o_stall,
    output logic [NM-1:0]       o_err,
    output logic                o_cyc,
    output logic                o_stb,
    output logic                o_we,
    output logic [AW-1:0]       o_adr,
    output logic [DW-1:0]       o_dat,
    input  logic                i_ack,
    input  logic                i_stall,
    input  logic                i_err,
    output logic [LGNM-1:0]     o_owner
);

    // Watchdog counter is sized for TIMEOUT and saturates one below it.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_MAX = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [LGNM-1:0] owner_q, owner_d;
    logic [LGNM-1:0] last_owner_q, last_owner_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [LGNM-1:0] winner;
    logic            owner_cyc;
    logic            timeout;

    assign owner_cyc = i_cyc[owner_q];
    assign o_owner   = owner_q;

    // Watchdog fires on the last allowed quiet BUSY clock; a simultaneous owner drop wins.
    assign timeout = (TIMEOUT != 0) && (state_q == S_BUSY) && owner_cyc
                     && (wd_q == WD_MAX) && !i_ack && !i_err;

    // Pick the winner: lowest index, or first requester after the last owner.
    always_comb begin
        int              base;
        logic            found;
        logic [LGNM-1:0] cand;
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        base   = (OPT_RR != 0) ? int'(last_owner_q) + 1 : 0;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NM; k++) begin
            cand = LGNM'((base + k) % NM);
            if (!found && i_cyc[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state logic for the grant FSM and the watchdog counter.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wd_d         = wd_q;
        case (state_q)
            S_IDLE: begin
                if (|i_cyc) begin
                    state_d      = S_BUSY;
                    owner_d      = winner;
                    last_owner_d = winner;
                    wd_d         = '0;
                end
            end
            S_BUSY: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    state_d = S_ABORT;
                end else if (i_ack || i_err) begin
                    wd_d = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ABORT: begin
                if (!owner_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments for every flop so all registers update from the same pre-edge values.
        if (i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_owner_q <= LGNM'(NM - 1);
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wd_q         <= wd_d;
        end
    end

    // Bus routing: owner sees the slave while BUSY, everyone else is stalled.
    always_comb begin
        o_cyc   = 1'b0;
        o_stb   = 1'b0;
        o_ack   = '0;
        o_err   = '0;
        o_stall = '1;
        o_we    = i_we[owner_q];
        o_adr   = i_adr[int'(owner_q) * AW +: AW];
        o_dat   = i_dat[int'(owner_q) * DW +: DW];
        if (state_q == S_BUSY) begin
            o_cyc            = owner_cyc;
            o_stb            = owner_cyc & i_stb[owner_q];
            o_ack[owner_q]   = i_ack;
            o_err[owner_q]   = i_err | timeout;
            o_stall[owner_q] = i_stall;
        end
    end

endmodule
